// File: rtl/mem_port_arbiter.sv
// Shares one single-port 16-bit memory between instruction fetch (IF) and load/store (DM).
// DM has priority; a saturating starvation counter forces an IF grant after STARVE_MAX DM wins.
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [15:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [15:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    output logic        misalign_err
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t      r_state, w_next;
    logic        r_own_dm, r_we, r_a0;
    logic [14:0] r_addr;
    logic [15:0] r_wdata, r_if_rdata, r_dm_rdata;
    logic [2:0]  r_lat_cnt, r_starve;
    logic        w_idle, w_starved, w_gnt_dm, w_gnt_if, w_last_wait;

    // Gated by rst so grants stay low while reset is held, although IDLE is the reset state.
    assign w_idle      = (r_state == S_IDLE) && rst;
    assign w_starved   = (r_starve == 3'(STARVE_MAX));
    assign w_gnt_dm    = w_idle && dm_req && !(if_req && w_starved);
    assign w_gnt_if    = w_idle && if_req && !w_gnt_dm;
    assign w_last_wait = (r_state == S_WAIT) && (r_lat_cnt == 3'(MEM_LAT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_gnt_if || w_gnt_dm) w_next = S_ISSUE;
            S_ISSUE: w_next = r_we ? S_DONE : S_WAIT;
            S_WAIT:  if (w_last_wait) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        if_gnt       = w_gnt_if;
        dm_gnt       = w_gnt_dm;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        misalign_err = 1'b0;
        if_rvalid    = 1'b0;
        dm_rvalid    = 1'b0;
        case (r_state)
            S_ISSUE: begin
                mem_en       = 1'b1;
                mem_we       = r_we;
                misalign_err = r_own_dm && r_a0;
            end
            S_DONE: begin
                if_rvalid = !r_own_dm;
                dm_rvalid = r_own_dm;
            end
            default: ;
        endcase
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign if_rdata  = r_if_rdata;
    assign dm_rdata  = r_dm_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_own_dm   <= 1'b0;
            r_we       <= 1'b0;
            r_a0       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_lat_cnt  <= '0;
            r_starve   <= '0;
        end else begin
            if (w_gnt_if || w_gnt_dm) begin
                r_own_dm <= w_gnt_dm;
                r_we     <= w_gnt_dm && dm_we;
                r_a0     <= w_gnt_dm ? dm_addr[0] : if_addr[0];
                r_addr   <= w_gnt_dm ? dm_addr[15:1] : if_addr[15:1];
                if (w_gnt_dm) r_wdata <= dm_wdata;
            end
            if (r_state == S_ISSUE)     r_lat_cnt <= '0;
            else if (r_state == S_WAIT) r_lat_cnt <= r_lat_cnt + 3'd1;
            if (w_last_wait) begin
                if (r_own_dm) r_dm_rdata <= mem_rdata;
                else          r_if_rdata <= mem_rdata;
            end
            if (w_gnt_if)
                r_starve <= '0;
            else if (w_gnt_dm && if_req && !w_starved)
                r_starve <= r_starve + 3'd1;
        end
    end
endmodule
